exu_div_iter: RTL and testbench

Iterative radix-2 integer divider for the EXU, the inverse counterpart of the pipelined multiplier: it takes operands from the same E1 issue point and returns either quotient or remainder. It is a non-pipelined, fixed-latency, single-operation-in-flight unit with a busy/finish handshake to decode and pipeline flush. It covers RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed-overflow results.

---
 rtl/exu_div_iter.sv | 135 +++++++++++++
 tb/tb_exu_div_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider for the EXU.
// One quotient bit per cycle; DIV/DIVU/REM/REMU results.
module exu_div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            valid,
   input  logic            unsign,
   input  logic            rem,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            freeze,
   input  logic            flush_lower,
   output logic            busy,
   output logic            finish,
   output logic [XLEN-1:0] out
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]   count;
   logic [XLEN:0]   r;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] m;
   logic [XLEN-1:0] a_orig;
   logic            sign_a;
   logic            sign_b;
   logic            dz;
   logic            rem_q;

   logic            accept;
   logic            adv;
   logic            sa_in;
   logic            sb_in;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   r_sh;
   logic [XLEN+1:0] diff;
   logic [XLEN-1:0] quot;
   logic [XLEN-1:0] remd;

   assign busy   = (state != IDLE);
   assign finish = (state == DONE);

   assign adv    = ~flush_lower & ~freeze;
   assign accept = adv & valid & (state == IDLE);

   assign sa_in  = ~unsign & dividend[XLEN-1];
   assign sb_in  = ~unsign & divisor[XLEN-1];
   assign a_mag  = sa_in ? ('0 - dividend) : dividend;
   assign b_mag  = sb_in ? ('0 - divisor) : divisor;

   // R stays below M, so the shifted partial remainder fits XLEN+1 bits
   assign r_sh   = {r[XLEN-1:0], q[XLEN-1]};
   assign diff   = {1'b0, r_sh} - {2'b0, m};

   always_comb begin
      quot = q;
      remd = r[XLEN-1:0];
      if (dz) begin
         quot = '1;
         remd = a_orig;
      end else begin
         if (sign_a ^ sign_b) quot = '0 - q;
         if (sign_a) remd = '0 - r[XLEN-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush_lower) begin
         state_nxt = IDLE;
      end else if (!freeze) begin
         unique case (state)
            IDLE: if (valid) state_nxt = RUN;
            RUN:  if (count == LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         count  <= '0;
         r      <= '0;
         q      <= '0;
         m      <= '0;
         a_orig <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dz     <= 1'b0;
         rem_q  <= 1'b0;
         out    <= '0;
      end else if (accept) begin
         count  <= '0;
         r      <= '0;
         q      <= a_mag;
         m      <= b_mag;
         a_orig <= dividend;
         sign_a <= sa_in;
         sign_b <= sb_in;
         dz     <= (divisor == '0);
         rem_q  <= rem;
      end else if (adv && state == RUN) begin
         count <= count + 1'b1;
         if (!diff[XLEN+1]) begin
            r <= diff[XLEN:0];
            q <= {q[XLEN-2:0], 1'b1};
         end else begin
            r <= r_sh;
            q <= {q[XLEN-2:0], 1'b0};
         end
      end else if (adv && state == FIX) begin
         out <= rem_q ? remd : quot;
      end
   end

endmodule

// File: tb/tb_exu_div_iter.sv
// Directed bench for exu_div_iter: latency, results,
// flush, freeze, ignored valid and async reset.
module tb_exu_div_iter;

   logic        clk;
   logic        rst_l;
   logic        valid;
   logic        unsign;
   logic        rem;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        freeze;
   logic        flush_lower;
   logic        busy;
   logic        finish;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   exu_div_iter dut (
      .clk         (clk),
      .rst_l       (rst_l),
      .valid       (valid),
      .unsign      (unsign),
      .rem         (rem),
      .dividend    (dividend),
      .divisor     (divisor),
      .freeze      (freeze),
      .flush_lower (flush_lower),
      .busy        (busy),
      .finish      (finish),
      .out         (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(
      input logic u, input logic r,
      input logic [31:0] a, input logic [31:0] b);
      logic [31:0] qv, rv;
      if (b == 32'd0) begin
         qv = '1;
         rv = a;
      end else if (u) begin
         qv = a / b;
         rv = a % b;
      end else if (a == 32'h8000_0000 && b == '1) begin
         qv = a;
         rv = 32'd0;
      end else begin
         qv = $signed(a) / $signed(b);
         rv = $signed(a) % $signed(b);
      end
      return r ? rv : qv;
   endfunction

   // Starts at a negedge in cycle 0; returns at the
   // negedge of the first cycle after finish drops.
   task automatic do_op(input string tag,
                        input logic u, input logic r,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat,
                        input int fz_at, input int fz_len,
                        input int dn_fz, input int v2_at);
      int n;
      int nb;
      valid    = 1'b1;
      unsign   = u;
      rem      = r;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      valid = 1'b0;
      n  = 1;
      nb = 0;
      while (finish !== 1'b1 && n < 80) begin
         if (busy !== 1'b1) nb++;
         freeze = (fz_len > 0) && (n >= fz_at) &&
                  (n < fz_at + fz_len);
         valid = (n == v2_at);
         if (n == v2_at) begin
            unsign   = ~u;
            rem      = ~r;
            dividend = 32'h0001_2345;
            divisor  = 32'd7;
         end
         @(negedge clk);
         n++;
      end
      valid  = 1'b0;
      freeze = 1'b0;
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_busy"}, 32'(nb), 32'd0);
      check({tag, "_out"}, out, exp);
      for (int k = 0; k < dn_fz; k++) begin
         freeze = 1'b1;
         @(negedge clk);
         check({tag, "_fzfin"}, 32'(finish), 32'd1);
      end
      freeze = 1'b0;
      @(negedge clk);
      check({tag, "_fin0"}, 32'(finish), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, e;
      logic        u, r;
      int          nf;
      rst_l       = 1'b0;
      valid       = 1'b0;
      unsign      = 1'b0;
      rem         = 1'b0;
      dividend    = '0;
      divisor     = '0;
      freeze      = 1'b0;
      flush_lower = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fin", 32'(finish), 32'd0);
      check("rst_out", out, 32'd0);
      rst_l = 1'b1;
      @(negedge clk);

      do_op("u20d3q", 1, 0, 32'd20, 32'd3,
            32'd6, 34, 0, 0, 0, 0);
      do_op("u20d3r", 1, 1, 32'd20, 32'd3,
            32'd2, 34, 0, 0, 0, 0);
      do_op("s20d3q", 0, 0, 32'd20, 32'd3,
            32'd6, 34, 0, 0, 0, 0);
      do_op("s20d3r", 0, 1, 32'd20, 32'd3,
            32'd2, 34, 0, 0, 0, 0);
      do_op("sm20q", 0, 0, 32'hFFFF_FFEC, 32'd3,
            32'hFFFF_FFFA, 34, 0, 0, 0, 0);
      do_op("sm20r", 0, 1, 32'hFFFF_FFEC, 32'd3,
            32'hFFFF_FFFE, 34, 0, 0, 0, 0);
      do_op("s20m3q", 0, 0, 32'd20, 32'hFFFF_FFFD,
            32'hFFFF_FFFA, 34, 0, 0, 0, 0);
      do_op("s20m3r", 0, 1, 32'd20, 32'hFFFF_FFFD,
            32'd2, 34, 0, 0, 0, 0);
      do_op("dzsq", 0, 0, 32'd7, 32'd0,
            32'hFFFF_FFFF, 34, 0, 0, 0, 0);
      do_op("dzsr", 0, 1, 32'd7, 32'd0,
            32'd7, 34, 0, 0, 0, 0);
      do_op("dzuq", 1, 0, 32'd7, 32'd0,
            32'hFFFF_FFFF, 34, 0, 0, 0, 0);
      do_op("dzur", 1, 1, 32'd7, 32'd0,
            32'd7, 34, 0, 0, 0, 0);
      do_op("ovfq", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 34, 0, 0, 0, 0);
      do_op("ovfr", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 34, 0, 0, 0, 0);

      // flush at cycle 10 of a 100/7 quotient
      valid    = 1'b1;
      unsign   = 1'b1;
      rem      = 1'b0;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      flush_lower = 1'b1;
      @(negedge clk);
      flush_lower = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_fin", 32'(finish), 32'd0);
      check("flush_out", out, 32'd0);
      do_op("postflush", 1, 0, 32'd1000, 32'd9,
            32'd111, 34, 0, 0, 0, 0);

      do_op("v2ign", 1, 1, 32'd1000, 32'd9,
            32'd1, 34, 0, 0, 0, 5);
      do_op("fzrun", 0, 0, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFF2, 38, 10, 4, 0, 0);
      do_op("fzdone", 0, 1, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFFE, 34, 0, 0, 3, 0);

      // async reset mid-run aborts with no finish
      valid    = 1'b1;
      dividend = 32'd55;
      divisor  = 32'd5;
      @(negedge clk);
      valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_l = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_out", out, 32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      nf = 0;
      repeat (40) begin
         @(negedge clk);
         if (finish === 1'b1) nf++;
      end
      check("arst_nofin", 32'(nf), 32'd0);

      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 100))
                          : $urandom;
         if (i == 5) b = 32'hFFFF_FFF9;
         u = 1'(i & 1);
         r = 1'((i >> 1) & 1);
         e = ref_div(u, r, a, b);
         do_op($sformatf("rnd%0d", i), u, r, a, b,
               e, 34, 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
